pattern_playback: RTL and testbench
===================================

// Module: pattern_playback
// PURPOSE
//  Computer side of the Simon-style sequence game: generates a pseudo-random
//  sequence of box symbols (0..3, one per key0..key3), stores it, and plays the
//  first `level` symbols back by flashing the matching 24x24 box on the VGA
//  pixel interface. Exposes the stored sequence through a read port so the
//  player-input checker can compare key presses against it.
// PARAMETERS
//  FLASH_CYCLES  25_000_000  clocks a box stays lit after it is fully drawn
//  GAP_CYCLES    12_500_000  clocks of blank time after each erase
//  SEED          8'hA5       LFSR reset value (must be non-zero)
// PORTS
//  iClock      in   1  system clock
//  iResetn     in   1  synchronous, active-low reset
//  new_game    in   1  pulse: refill sequence memory from LFSR
//  start       in   1  pulse: play back first `level` symbols
//  level       in   4  number of symbols to play (0..15)
//  seq_idx     in   4  read address into sequence memory
//  seq_sym     out  2  combinational read data, mem[seq_idx]
//  busy        out  1  high whenever state != S_IDLE
//  done        out  1  one-cycle pulse at end of fill or playback
//  oX          out  8  pixel x
//  oY          out  7  pixel y
//  oColour     out  3  pixel colour
//  oPlot       out  1  pixel write strobe
// BEHAVIOUR
//  Reset: state S_IDLE, lfsr=SEED, all 16 mem entries=0, counters=0,
//   oX=0, oY=0, oColour=0, oPlot=0, done=0, busy=0. Reset mid-op aborts at once.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback to bit0;
//   advances every clock in all states (start timing adds randomness).
//  Box origins (top-left): sym0 (38,54), sym1 (68,84), sym2 (68,54), sym3 (98,54).
//  States:
//   S_IDLE : new_game -> S_FILL; else start -> S_LOAD. new_game wins if both.
//            start/new_game in any other state are ignored (no queueing).
//   S_FILL : 16 cycles; cycle i writes mem[i] <= lfsr[1:0] (value before
//            that cycle's advance); after i=15 -> S_DONE.
//   S_LOAD : idx<=0; level==0 -> S_DONE (no pixels); else -> S_DRAW.
//   S_DRAW : dx,dy scan 0..23, dx fastest; one pixel/cycle, colour 3'd5;
//            576 cycles; after (23,23) -> S_HOLD.
//   S_HOLD : FLASH_CYCLES cycles, oPlot=0 -> S_ERASE.
//   S_ERASE: same scan as S_DRAW, colour 3'd7 (background) -> S_GAP.
//   S_GAP  : GAP_CYCLES cycles; then idx+1==level -> S_DONE, else idx++ -> S_DRAW.
//   S_DONE : done=1 for exactly this cycle -> S_IDLE.
//  Pixel outputs registered: in the cycle after a DRAW/ERASE state cycle with
//   scan (dx,dy), oX=boxX+dx, oY=boxY+dy, oPlot=1; otherwise oPlot=0 and
//   oX/oY/oColour hold last value. First pixel appears 2 cycles after the cycle
//   start is sampled (IDLE->LOAD->DRAW). Exactly 576 oPlot cycles per draw.
//  Widths: dx,dy 5-bit; boxX+dx fits 8 bits, boxY+dy fits 7 bits (max 121<128
//   not reached: max y 107). Hold/gap counters 25-bit, count to param-1.
//  mem is written only in S_FILL; seq_sym valid in all states incl. during play.
// TESTING (bench uses FLASH_CYCLES=4, GAP_CYCLES=3)
//  1 Reset then idle 5 cycles -> all outputs 0, seq_sym=0 for every seq_idx.
//  2 Reset, new_game 1 cycle -> busy 17 cycles, done pulse once, mem[0]=2'b01,
//    mem[1..15] match software LFSR model from 8'hA5.
//  3 Fill, start with level=1 -> oPlot high 576 cycles colour 5 at box mem[0]
//    (first pixel (68,84) if sym1), 4 idle, 576 cycles colour 7, 3 idle, done.
//  4 start with level=0 -> done pulse 2 cycles later, oPlot never asserted.
//  5 level=3: boxes drawn in order mem[0],mem[1],mem[2]; pulse start and
//    new_game mid-play -> ignored, mem unchanged; new_game+start same cycle in
//    IDLE -> fill only, no playback.
//  6 Assert iResetn=0 during S_DRAW pixel 100 -> next cycle oPlot=0, busy=0,
//    mem all 0, lfsr=8'hA5; subsequent new_game reproduces test 2 sequence.

Source files
------------

// File: rtl/pattern_playback.sv
// rtl/pattern_playback.sv - Simon-style sequence generator with VGA box playback
//
// Purpose:
//   Computer side of the sequence game. An 8-bit LFSR runs every clock; on
//   new_game its low two bits are sampled on 16 consecutive cycles to fill the
//   sequence memory. On start, the first `level` stored symbols are played
//   back. Each symbol is shown by drawing its 24x24 box and holding it lit.
//   The box is then erased to background colour, followed by a blank gap.
//
// Ports:
//   iClock, iResetn   clock, synchronous active-low reset
//   new_game          pulse, refill sequence memory (accepted only when idle)
//   start             pulse, play back first `level` symbols (idle only)
//   level[3:0]        number of symbols to play, sampled with start
//   seq_idx[3:0]      read address into sequence memory
//   seq_sym[1:0]      combinational read data mem[seq_idx]
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse at the end of a fill or playback
//   oX[7:0], oY[6:0]  registered pixel coordinate
//   oColour[2:0]      registered pixel colour
//   oPlot             registered pixel write strobe
module pattern_playback #(
  parameter int         FLASH_CYCLES = 25_000_000,
  parameter int         GAP_CYCLES   = 12_500_000,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       new_game,
  input  logic       start,
  input  logic [3:0] level,
  input  logic [3:0] seq_idx,
  output logic [1:0] seq_sym,
  output logic       busy,
  output logic       done,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_DRAW,
    S_HOLD,
    S_ERASE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [24:0] HOLD_LAST = 25'(FLASH_CYCLES - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);
  localparam logic [4:0]  SCAN_LAST = 5'd23;
  localparam logic [2:0]  COL_BOX   = 3'd5;
  localparam logic [2:0]  COL_BG    = 3'd7;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_lfsr;
  logic        w_feedback;
  logic [1:0]  r_mem [16];

  logic [3:0]  r_idx;
  logic [3:0]  r_level;
  logic [4:0]  r_dx;
  logic [4:0]  r_dy;
  logic [24:0] r_cnt;

  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;

  logic        w_scan_last;
  logic        w_hold_last;
  logic        w_gap_last;
  logic        w_last_box;
  logic [1:0]  w_sym;
  logic [7:0]  w_box_x;
  logic [6:0]  w_box_y;

  // x^8+x^6+x^5+x^4+1, shifted left with the feedback entering bit 0
  assign w_feedback  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  assign w_scan_last = (r_dx == SCAN_LAST) && (r_dy == SCAN_LAST);
  assign w_hold_last = (r_cnt == HOLD_LAST);
  assign w_gap_last  = (r_cnt == GAP_LAST);
  // widened so idx+1 cannot wrap before the compare
  assign w_last_box  = (({1'b0, r_idx} + 5'd1) == {1'b0, r_level});

  assign w_sym       = r_mem[r_idx];
  assign seq_sym     = r_mem[seq_idx];

  assign oX          = r_x;
  assign oY          = r_y;
  assign oColour     = r_colour;
  assign oPlot       = r_plot;

  // top-left corner of the box belonging to the symbol being played
  always_comb begin
    w_box_x = 8'd38;
    w_box_y = 7'd54;
    case (w_sym)
      2'd0: begin w_box_x = 8'd38; w_box_y = 7'd54; end
      2'd1: begin w_box_x = 8'd68; w_box_y = 7'd84; end
      2'd2: begin w_box_x = 8'd68; w_box_y = 7'd54; end
      2'd3: begin w_box_x = 8'd98; w_box_y = 7'd54; end
      default: begin w_box_x = 8'd38; w_box_y = 7'd54; end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // a refill takes priority over playback when both arrive together
        if (new_game) begin
          w_next = S_FILL;
        end else if (start) begin
          w_next = S_LOAD;
        end
      end
      S_FILL: begin
        if (r_idx == 4'd15) begin
          w_next = S_DONE;
        end
      end
      S_LOAD: begin
        w_next = (r_level == 4'd0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        if (w_scan_last) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hold_last) begin
          w_next = S_ERASE;
        end
      end
      S_ERASE: begin
        if (w_scan_last) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_next = w_last_box ? S_DONE : S_DRAW;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // free-running so the moment a player presses start perturbs the sequence
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_feedback};
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 2'd0;
      end
    end else if (r_state == S_FILL) begin
      r_mem[r_idx] <= r_lfsr[1:0];
    end
  end

  // r_idx doubles as the fill address and the playback symbol index
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_idx   <= 4'd0;
      r_level <= 4'd0;
      r_dx    <= 5'd0;
      r_dy    <= 5'd0;
      r_cnt   <= 25'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (new_game) begin
            r_idx <= 4'd0;
          end else if (start) begin
            // latched so a level change mid-play cannot strand the sequencer
            r_level <= level;
          end
        end
        S_FILL: begin
          r_idx <= r_idx + 4'd1;
        end
        S_LOAD: begin
          r_idx <= 4'd0;
          r_dx  <= 5'd0;
          r_dy  <= 5'd0;
          r_cnt <= 25'd0;
        end
        S_DRAW, S_ERASE: begin
          if (r_dx == SCAN_LAST) begin
            r_dx <= 5'd0;
            r_dy <= (r_dy == SCAN_LAST) ? 5'd0 : r_dy + 5'd1;
          end else begin
            r_dx <= r_dx + 5'd1;
          end
        end
        S_HOLD: begin
          r_cnt <= w_hold_last ? 25'd0 : r_cnt + 25'd1;
        end
        S_GAP: begin
          if (w_gap_last) begin
            r_cnt <= 25'd0;
            if (!w_last_box) begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // pixel lags the scan by one cycle; coordinates and colour hold between plots
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
    end else if ((r_state == S_DRAW) || (r_state == S_ERASE)) begin
      r_x      <= w_box_x + {3'b000, r_dx};
      r_y      <= w_box_y + {2'b00, r_dy};
      r_colour <= (r_state == S_DRAW) ? COL_BOX : COL_BG;
      r_plot   <= 1'b1;
    end else begin
      r_plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_playback.sv
// tb/tb_pattern_playback.sv - randomized bench with a schedule-based reference model
`timescale 1ns/1ps
module tb_pattern_playback;

  localparam int FLASH = 4;
  localparam int GAP   = 3;

  logic       iClock   = 1'b0;
  logic       iResetn  = 1'b0;
  logic       new_game = 1'b0;
  logic       start    = 1'b0;
  logic [3:0] level    = 4'd0;
  logic [3:0] seq_idx  = 4'd0;
  logic [1:0] seq_sym;
  logic       busy;
  logic       done;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;

  pattern_playback #(
    .FLASH_CYCLES(FLASH),
    .GAP_CYCLES  (GAP),
    .SEED        (8'hA5)
  ) dut (
    .iClock  (iClock),
    .iResetn (iResetn),
    .new_game(new_game),
    .start   (start),
    .level   (level),
    .seq_idx (seq_idx),
    .seq_sym (seq_sym),
    .busy    (busy),
    .done    (done),
    .oX      (oX),
    .oY      (oY),
    .oColour (oColour),
    .oPlot   (oPlot)
  );

  always #5 iClock = ~iClock;

  // one entry per controller cycle: what that cycle looks like and the pixel it issues
  typedef struct {
    bit         busy;
    bit         done;
    bit         fill;
    bit         commit;
    bit         pv;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } rec_t;

  rec_t       m_q[$];
  rec_t       m_last;
  rec_t       c_rec;
  logic [1:0] m_mem[16];
  logic [1:0] m_pend[16];
  logic [1:0] saved[16];
  logic [7:0] m_lfsr;
  bit         m_ready    = 0;
  bit         m_cur_busy = 0;
  logic [7:0] m_hx;
  logic [6:0] m_hy;
  logic [2:0] m_hc;
  int         box_x[4]   = '{38, 68, 68, 98};
  int         box_y[4]   = '{54, 84, 54, 54};
  int         n_vec      = 0;
  int         n_err      = 0;
  int         plot_total = 0;

  function automatic rec_t mk(input bit b, input bit d, input bit f, input bit c,
                              input bit pv, input int x, input int y, input int col);
    rec_t r;
    r.busy = b; r.done = d; r.fill = f; r.commit = c; r.pv = pv;
    r.x = 8'(x); r.y = 7'(y); r.col = 3'(col);
    return r;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sched_fill();
    logic [7:0] t;
    t = m_lfsr;
    for (int i = 0; i < 16; i++) begin
      t = lfsr_next(t);
      m_pend[i] = t[1:0];
      m_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    end
    m_q.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
  endtask

  task automatic sched_play(input int lvl);
    m_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int b = 0; b < lvl; b++) begin
      int bx;
      int by;
      bx = box_x[m_mem[b]];
      by = box_y[m_mem[b]];
      for (int pass = 0; pass < 2; pass++) begin
        for (int dy = 0; dy < 24; dy++)
          for (int dx = 0; dx < 24; dx++)
            m_q.push_back(mk(1, 0, 0, 0, 1, bx + dx, by + dy, (pass == 0) ? 5 : 7));
        repeat ((pass == 0) ? FLASH : GAP) m_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      end
    end
    m_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
  endtask

  // model: decides on commands as the design samples them, at the clock edge
  initial begin
    forever begin
      @(posedge iClock);
      if (!iResetn) begin
        m_q.delete();
        for (int i = 0; i < 16; i++) m_mem[i] = 2'd0;
        m_lfsr     = 8'hA5;
        m_cur_busy = 0;
        m_last     = mk(0, 0, 0, 0, 0, 0, 0, 0);
        m_hx = 8'd0; m_hy = 7'd0; m_hc = 3'd0;
        m_ready    = 1;
      end else begin
        if (!m_cur_busy) begin
          if (new_game) sched_fill();
          else if (start) sched_play(int'(level));
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  end

  // compare: every cycle, away from the clock edge
  initial begin
    forever begin
      @(negedge iClock);
      if (m_ready) begin
        c_rec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (m_q.size() > 0) c_rec = m_q.pop_front();
        n_vec++;
        if (m_last.pv) begin
          m_hx = m_last.x; m_hy = m_last.y; m_hc = m_last.col;
        end
        if (c_rec.commit) m_mem = m_pend;
        chk("busy", busy, c_rec.busy);
        chk("done", done, c_rec.done);
        chk("oPlot", oPlot, m_last.pv);
        chk("oX", oX, m_hx);
        chk("oY", oY, m_hy);
        chk("oColour", oColour, m_hc);
        if (!c_rec.fill) chk("seq_sym", seq_sym, m_mem[seq_idx]);
        if (oPlot === 1'b1) plot_total++;
        m_last     = c_rec;
        m_cur_busy = c_rec.busy;
      end
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
    seq_idx = 4'($urandom_range(0, 15));
  endtask

  task automatic pulse(input logic ng, input logic st);
    new_game = ng;
    start    = st;
    tick();
    new_game = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_reset();
    iResetn  = 1'b0;
    new_game = 1'b0;
    start    = 1'b0;
    tick();
    tick();
    iResetn  = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iClock);
      if (busy === 1'b0 && m_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
    @(posedge iClock);
    #1;
  endtask

  initial begin
    int         nb, nd, plots, c5, c7, fx, fy, fc, done_at, p0, cnt;
    bit         first;
    logic [1:0] exp4[4];
    exp4 = '{2'd1, 2'd2, 2'd0, 2'd1};

    // reset state and idle read-back
    do_reset();
    repeat (5) tick();
    for (int i = 0; i < 16; i++) begin
      seq_idx = 4'(i);
      @(negedge iClock);
      chk("t1_seq_sym", seq_sym, 0);
      chk("t1_busy", busy, 0);
      chk("t1_oPlot", oPlot, 0);
      chk("t1_oX", oX, 0);
      @(posedge iClock);
      #1;
    end

    // fill: one idle cycle after reset, then new_game
    do_reset();
    tick();
    pulse(1'b1, 1'b0);
    nb = 0; nd = 0;
    repeat (30) begin
      @(negedge iClock);
      nb += int'(busy);
      nd += int'(done);
    end
    @(posedge iClock);
    #1;
    chk("t2_busy_cycles", nb, 17);
    chk("t2_done_pulses", nd, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_model_mem", m_mem[i], exp4[i]);
      seq_idx = 4'(i);
      #1;
      chk("t2_seq_sym", seq_sym, exp4[i]);
    end
    saved = m_mem;
    tick();

    // single-symbol playback
    level = 4'd1;
    pulse(1'b0, 1'b1);
    plots = 0; c5 = 0; c7 = 0; nd = 0; first = 0; fx = 0; fy = 0; fc = 0;
    repeat (1200) begin
      @(negedge iClock);
      if (oPlot === 1'b1) begin
        plots++;
        if (!first) begin
          first = 1; fx = int'(oX); fy = int'(oY); fc = int'(oColour);
        end
        if (oColour == 3'd5) c5++;
        else if (oColour == 3'd7) c7++;
      end
      nd += int'(done);
    end
    @(posedge iClock);
    #1;
    chk("t3_plots", plots, 1152);
    chk("t3_draw_pixels", c5, 576);
    chk("t3_erase_pixels", c7, 576);
    chk("t3_done", nd, 1);
    chk("t3_first_x", fx, 68);
    chk("t3_first_y", fy, 84);
    chk("t3_first_colour", fc, 5);

    // level zero: done two cycles after start, no pixels
    level = 4'd0;
    pulse(1'b0, 1'b1);
    done_at = 0; plots = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge iClock);
      if (done === 1'b1 && done_at == 0) done_at = k;
      plots += int'(oPlot);
    end
    @(posedge iClock);
    #1;
    chk("t4_done_at", done_at, 2);
    chk("t4_plots", plots, 0);

    // three symbols with commands arriving mid-play
    level = 4'd3;
    p0 = plot_total;
    pulse(1'b0, 1'b1);
    repeat (40) tick();
    pulse(1'b0, 1'b1);
    repeat (650) tick();
    pulse(1'b1, 1'b0);
    wait_idle(5000);
    chk("t5_plots", plot_total - p0, 3456);
    for (int i = 0; i < 16; i++) chk("t5_mem_kept", m_mem[i], saved[i]);
    p0 = plot_total;
    pulse(1'b1, 1'b1);
    wait_idle(100);
    chk("t5_fill_only_plots", plot_total - p0, 0);

    // randomized command mix
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 2) == 0) begin
        pulse(1'b1, 1'b0);
      end else begin
        level = 4'($urandom_range(0, 2));
        pulse(1'b0, 1'b1);
      end
      wait_idle(4000);
    end

    // reset during a draw, then reproduce the original sequence
    level = 4'd2;
    pulse(1'b0, 1'b1);
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < 100; c++) begin
      @(negedge iClock);
      cnt += int'(oPlot);
    end
    chk("t6_reached_pixel_100", cnt, 100);
    iResetn = 1'b0;
    @(posedge iClock);
    #1;
    iResetn = 1'b1;
    seq_idx = 4'd5;
    @(negedge iClock);
    chk("t6_busy", busy, 0);
    chk("t6_oPlot", oPlot, 0);
    chk("t6_done", done, 0);
    chk("t6_seq_sym", seq_sym, 0);
    tick();
    pulse(1'b1, 1'b0);
    wait_idle(100);
    for (int i = 0; i < 16; i++) begin
      chk("t6_model_repro", m_mem[i], saved[i]);
      seq_idx = 4'(i);
      #1;
      chk("t6_seq_repro", seq_sym, saved[i]);
    end
    for (int i = 0; i < 4; i++) chk("t6_pin", saved[i], exp4[i]);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
